// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Each bit is held for PRESCALE clock cycles, with PRESCALE latched when the frame is accepted.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [5:0]            r_prescale;
  logic                  r_tx;
  logic                  r_busy;

  state_t                w_state_next;
  logic [5:0]            w_edge_next;
  logic [BIT_W-1:0]      w_bit_next;
  logic [5:0]            w_prescale;
  logic                  w_bit_done;
  logic                  w_accept;
  logic                  w_tx_next;
  logic                  w_busy_next;

  // A zero prescale would never complete a bit, so it behaves as one cycle per bit.
  assign w_prescale = (PRESCALE == 6'd0) ? 6'd1 : PRESCALE;
  assign w_bit_done = (r_edge_cnt == (r_prescale - 6'd1));
  assign w_accept   = (r_state == IDLE) && DATA_VALID;

  // State register plus frame latches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= 6'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_edge_cnt <= w_edge_next;
      r_bit_cnt  <= w_bit_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      if (w_accept) begin
        r_data     <= P_DATA;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_prescale <= w_prescale;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_next = r_state;
    w_edge_next  = 6'd0;
    w_bit_next   = '0;
    if (r_state != IDLE) begin
      w_edge_next = w_bit_done ? 6'd0 : (r_edge_cnt + 6'd1);
    end
    case (r_state)
      IDLE: begin
        if (DATA_VALID) w_state_next = START;
      end
      START: begin
        if (w_bit_done) w_state_next = DATA;
      end
      DATA: begin
        w_bit_next = r_bit_cnt;
        if (w_bit_done) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_next   = '0;
            w_state_next = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_done) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops present each bit on its first cycle.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != IDLE);
    case (w_state_next)
      IDLE:    w_tx_next = 1'b1;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_next];
      PARITY:  w_tx_next = r_par_typ ? ~^r_data : ^r_data;
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-written frame bit patterns checked cycle by cycle
// on the falling clock edge, with BUSY required high throughout each frame and low right after.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input int obs, input int exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the first falling edge after acceptance.
  task automatic request(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    PRESCALE   = ps;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // exp holds the frame in time order from bit n-1 down to bit 0; each bit must last p cycles
  // with BUSY high, and the cycle after the frame must be idle. Ends on that idle cycle.
  task automatic expect_frame(input logic [10:0] exp, input int n, input int p, input string tag);
    int good;
    for (int i = 0; i < n; i++) begin
      good = 0;
      for (int c = 0; c < p; c++) begin
        if (TX_OUT === exp[n-1-i] && BUSY === 1'b1) good++;
        @(negedge CLK);
      end
      chk(good, p, $sformatf("%s bit%0d", tag, i));
    end
    chk(int'(BUSY), 0, {tag, " busy_end"});
    chk(int'(TX_OUT), 1, {tag, " tx_end"});
    $display("frame %s: %0d bits x %0d cycles checked", tag, n, p);
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    int good;
    good = 0;
    for (int c = 0; c < cycles; c++) begin
      if (TX_OUT === 1'b1 && BUSY === 1'b0) good++;
      @(negedge CLK);
    end
    chk(good, cycles, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    PRESCALE   = 6'd8;
    repeat (3) @(negedge CLK);
    chk(int'(TX_OUT), 1, "reset tx");
    chk(int'(BUSY), 0, "reset busy");
    RST = 1'b0;
    @(negedge CLK);

    // Plain frame 0xA5, P=8
    request(8'hA5, 1'b0, 1'b0, 6'd8);
    expect_frame(11'b0101001011, 10, 8, "plain_a5");
    expect_idle(5, "plain_after");

    // Parity frames 0xA5, P=16
    request(8'hA5, 1'b1, 1'b0, 6'd16);
    expect_frame(11'b01010010101, 11, 16, "even_a5");
    request(8'hA5, 1'b1, 1'b1, 6'd16);
    expect_frame(11'b01010010111, 11, 16, "odd_a5");

    // Minimum prescale, 0x01 with odd parity, PRESCALE=1 then 0
    request(8'h01, 1'b1, 1'b1, 6'd1);
    expect_frame(11'b01000000001, 11, 1, "ps1_01");
    request(8'h01, 1'b1, 1'b1, 6'd0);
    expect_frame(11'b01000000001, 11, 1, "ps0_01");

    // DATA_VALID held high: back-to-back frames with one idle cycle between
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    PRESCALE   = 6'd8;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hC3;
    expect_frame(11'b0001111001, 10, 8, "b2b_3c");
    @(negedge CLK);
    DATA_VALID = 1'b0;
    expect_frame(11'b0110000111, 10, 8, "b2b_c3");

    // DATA_VALID pulses while busy must not start another frame
    request(8'h3C, 1'b0, 1'b0, 6'd8);
    fork
      expect_frame(11'b0001111001, 10, 8, "pulse_3c");
      begin
        repeat (20) @(negedge CLK);
        DATA_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (40) @(negedge CLK);
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
      end
    join
    expect_idle(20, "pulse_no_extra");

    // Inputs changed during DATA must not affect the frame in flight
    request(8'hFF, 1'b0, 1'b0, 6'd8);
    fork
      expect_frame(11'b0111111111, 10, 8, "midchg_ff");
      begin
        repeat (20) @(negedge CLK);
        P_DATA   = 8'h00;
        PRESCALE = 6'd16;
        PAR_EN   = 1'b1;
      end
    join

    // Reset during data bit 3 of 0x00 (line low there), then a clean 0x5A frame
    request(8'h00, 1'b0, 1'b0, 6'd8);
    repeat (34) @(negedge CLK);
    chk(int'(TX_OUT), 0, "pre_rst tx");
    RST = 1'b1;
    #1;
    chk(int'(TX_OUT), 1, "async_rst tx");
    chk(int'(BUSY), 0, "async_rst busy");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    expect_idle(3, "post_rst_idle");
    request(8'h5A, 1'b0, 1'b0, 6'd8);
    expect_frame(11'b0010110101, 10, 8, "post_rst_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter paired with the receive path. Serializes one 8-bit parallel word into an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. Runs on the same oversampling clock domain and PRESCALE setting as the receiver, holding each bit for PRESCALE clock cycles. Driven by the system controller or FIFO through a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, data bits per frame. Counter widths derive from it. Only 8 is verified.

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
P_DATA  input  8  parallel word to transmit
DATA_VALID  input  1  request to send P_DATA
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
PRESCALE  input  6  clock cycles per bit
TX_OUT  output  1  serial line, registered, idles high
BUSY  output  1  frame in progress, registered

Behaviour:
- Reset:
  - Asynchronous, takes effect on RST rise.
  - State goes to IDLE. TX_OUT=1, BUSY=0. All counters and latches clear.
  - Reset mid-frame aborts the frame immediately. No partial stop bit is sent.
- Bit period:
  - P = PRESCALE. PRESCALE=0 is treated as 1.
  - P is latched at frame acceptance. Changes to PRESCALE mid-frame have no effect.
- Handshake:
  - A frame is accepted on the rising edge where DATA_VALID=1 and the state is IDLE.
  - At that edge, P_DATA, PAR_EN, PAR_TYP and P are latched.
  - DATA_VALID while BUSY=1 is ignored. It is not queued.
  - P_DATA and the parity controls may change freely after acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1, BUSY=0. On accept, go to START.
  - START: TX_OUT=0 for P cycles, then go to DATA.
  - DATA: TX_OUT=data[bit_cnt], starting at bit_cnt=0 (LSB). Each bit is held P cycles. After bit 7, go to PARITY if the latched PAR_EN=1, else go to STOP.
  - PARITY: TX_OUT=^data when PAR_TYP=0, or ~^data when PAR_TYP=1, computed on the latched word. Held P cycles, then go to STOP.
  - STOP: TX_OUT=1 for P cycles, then go to IDLE.
- Timing:
  - Accept at edge k: TX_OUT=0 and BUSY=1 are visible from cycle k+1.
  - BUSY stays high for exactly 10*P cycles without parity, or 11*P with parity.
  - BUSY falls with the first IDLE cycle.
  - There is at least one IDLE cycle (TX_OUT=1, BUSY=0) between consecutive frames, so back-to-back requests yield a frame period of 10*P+1 or 11*P+1.
- Counters:
  - Edge counter, 6 bits: counts 0..P-1 within a bit. It wraps to 0 on each bit boundary and never exceeds P-1.
  - Bit counter, 3 bits: advances only in DATA at an edge-counter wrap.
  - Both counters are held at 0 in IDLE.
- Output glitch-freedom: TX_OUT comes from a flop and changes only at bit boundaries.

Test Plan:
- Plain frame: P=8, PAR_EN=0, send 0xA5.
  - TX_OUT must be 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles.
  - BUSY must be high for exactly 80 cycles.
  - TX_OUT must be 1 afterwards.
- Parity, P=16, 0xA5 (four ones):
  - PAR_TYP=0 gives parity bit 0.
  - PAR_TYP=1 gives parity bit 1.
  - BUSY must be high for 176 cycles in both cases.
- Minimum prescale: PRESCALE=1 and PRESCALE=0, 0x01, odd parity.
  - TX_OUT must be 0,1,0,0,0,0,0,0,0,0,1 (parity bit 0, since the word has one set bit), one cycle per bit.
  - Both settings must give identical waveforms.
- Handshake: hold DATA_VALID=1 continuously, P=8, data 0x3C then 0xC3.
  - Frames must be separated by exactly one idle cycle.
  - The second frame must carry P_DATA as sampled at its own accept edge.
  - Pulses of DATA_VALID while BUSY=1 must produce no extra frame.
- Mid-frame input changes: after accepting 0xFF at P=8, change P_DATA to 0x00, PRESCALE to 16 and PAR_EN to 1 during the DATA state.
  - The frame must still be 0xFF, 8 cycles per bit, no parity, 80 BUSY cycles.
- Reset mid-frame: assert RST during data bit 3.
  - TX_OUT=1 and BUSY=0 must take effect immediately, without waiting for a CLK edge.
  - After release, a new request for 0x5A must produce a complete, correct frame.
